// File: rtl/mesaj_alici.sv
// Serial-to-parallel message receiver: assembles MSB-first framed bits into a
// MSG_W-bit word and offers it downstream through a valid/ready output register.
module mesaj_alici #(
  parameter int MSG_W   = 16,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cerceve_basla,
  input  logic             bit_gecerli,
  input  logic             bit_veri,
  input  logic             mesaj_hazir,
  input  logic             tasma_temizle,
  output logic [MSG_W-1:0] mesaj,
  output logic             mesaj_gecerli,
  output logic             tasma,
  output logic             zaman_asimi,
  output logic [CNT_W-1:0] bit_sayisi
);

  localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {BOSTA, ALIM} state_e;

  state_e             state_q;
  logic [MSG_W-2:0]   sr_q;      // the final bit bypasses the register straight into the word
  logic [CNT_W-1:0]   cnt_q;
  logic [IDLE_W-1:0]  idle_q;
  logic [MSG_W-1:0]   mesaj_q;
  logic               gecerli_q;
  logic               tasma_q;
  logic               zaman_q;

  logic [MSG_W-1:0]   word;
  logic               last_bit;
  logic               idle_expired;
  logic               slot_free;

  assign word         = {sr_q, bit_veri};
  assign last_bit     = (cnt_q == CNT_W'(MSG_W - 1));
  // Abort on the cycle the idle counter would step onto TIMEOUT-1.
  assign idle_expired = (idle_q == IDLE_W'(TIMEOUT - 2));
  assign slot_free    = !gecerli_q || mesaj_hazir;

  // NOTE: every register here, including the message output, is reset so a
  // mid-frame reset leaves no stale word visible; all updates use <= so each
  // branch reads the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOSTA;
      sr_q      <= '0;
      cnt_q     <= '0;
      idle_q    <= '0;
      mesaj_q   <= '0;
      gecerli_q <= 1'b0;
      tasma_q   <= 1'b0;
      zaman_q   <= 1'b0;
    end else begin
      zaman_q <= 1'b0;

      if (gecerli_q && mesaj_hazir) begin
        gecerli_q <= 1'b0;
      end
      if (tasma_temizle) begin
        tasma_q <= 1'b0;
      end

      if (cerceve_basla) begin
        state_q <= ALIM;
        idle_q  <= '0;
        if (bit_gecerli) begin
          sr_q  <= (MSG_W-1)'(bit_veri);
          cnt_q <= CNT_W'(1);
        end else begin
          sr_q  <= '0;
          cnt_q <= '0;
        end
      end else if (state_q == ALIM) begin
        if (bit_gecerli) begin
          idle_q <= '0;
          if (last_bit) begin
            state_q <= BOSTA;
            sr_q    <= '0;
            cnt_q   <= '0;
            if (slot_free) begin
              mesaj_q   <= word;
              gecerli_q <= 1'b1;
            end else begin
              tasma_q <= 1'b1;
            end
          end else begin
            sr_q  <= word[MSG_W-2:0];
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end else if (idle_expired) begin
          state_q <= BOSTA;
          sr_q    <= '0;
          cnt_q   <= '0;
          idle_q  <= '0;
          zaman_q <= 1'b1;
        end else begin
          idle_q <= idle_q + IDLE_W'(1);
        end
      end
    end
  end

  assign mesaj         = mesaj_q;
  assign mesaj_gecerli = gecerli_q;
  assign tasma         = tasma_q;
  assign zaman_asimi   = zaman_q;
  assign bit_sayisi    = cnt_q;

endmodule

// File: doc/mesaj_alici.md
Name: mesaj_alici

Overview:
- Serial-to-parallel message receiver. Sits directly upstream of koordinat_belirleme.
- Assembles framed serial bits into a 16-bit message and holds it in an output register.
- Presents the message through a valid/ready handshake. The mesaj output drives the region decoder's mesaj input.
- Flags overruns (complete frame with no free output slot) and inter-bit timeouts.

Parameters:
- MSG_W, 16, message width in bits; also the number of bits per frame.
- CNT_W, 5, width of bit counter; must satisfy 2^CNT_W > MSG_W.
- TIMEOUT, 64, max idle cycles allowed between bits inside a frame before abort; must be >= 2.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cerceve_basla  in  1  frame-start strobe; starts or restarts assembly.
- bit_gecerli  in  1  serial bit strobe; bit_veri is sampled when high.
- bit_veri  in  1  serial data bit, MSB first.
- mesaj_hazir  in  1  downstream ready.
- tasma_temizle  in  1  clears the sticky overrun flag.
- mesaj  out  MSG_W  held message (output register).
- mesaj_gecerli  out  1  mesaj holds an unconsumed message.
- tasma  out  1  sticky overrun flag.
- zaman_asimi  out  1  one-cycle pulse on frame abort by timeout.
- bit_sayisi  out  CNT_W  bits accepted in the current frame; 0 in BOSTA.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=BOSTA; shift register, bit counter and idle counter = 0.
  - mesaj=0, mesaj_gecerli=0, tasma=0, zaman_asimi=0, bit_sayisi=0.
  - Reset mid-frame discards the partial frame and any held message.
- States: BOSTA (idle), ALIM (receiving).
- BOSTA:
  - bit_gecerli without cerceve_basla is ignored.
  - cerceve_basla=1 -> ALIM, counter=0, idle counter=0.
- Start and bit in the same cycle:
  - If bit_gecerli=1 in the cerceve_basla cycle, that bit is frame bit 0 (lands in MSB) and the counter becomes 1.
  - This rule applies in both BOSTA and ALIM.
- ALIM, on bit_gecerli: shift {sr[MSG_W-2:0], bit_veri}, counter+1, idle counter=0.
- ALIM, on any cycle without bit_gecerli: idle counter+1.
- cerceve_basla in ALIM: restart. Partial bits are discarded, counter reset, no error flag.
- Frame completion, on the cycle the MSG_W-th bit is accepted:
  - The assembled word is {sr[MSG_W-2:0], bit_veri}; the state returns to BOSTA.
  - Output slot free = (mesaj_gecerli=0) or (mesaj_hazir=1) in that cycle.
  - If free: mesaj <= word and mesaj_gecerli=1 from the next cycle. Latency is 1 clock from the last bit strobe.
  - If not free: the word is dropped, tasma <= 1, and mesaj and mesaj_gecerli are unchanged.
- Timeout:
  - In ALIM, when the idle counter reaches TIMEOUT-1 with no bit_gecerli, abort to BOSTA.
  - zaman_asimi is high for exactly the next cycle; counter and shift register are cleared.
  - A bit_gecerli in the terminal cycle wins: the bit is accepted and there is no timeout.
- Output handshake:
  - A transfer occurs on a cycle with mesaj_gecerli=1 and mesaj_hazir=1.
  - After a transfer, mesaj_gecerli drops the next cycle, unless a frame completes in the same cycle; then the new word loads and mesaj_gecerli stays 1.
  - mesaj is stable while mesaj_gecerli=1 and mesaj_hazir=0.
  - mesaj_hazir is ignored while mesaj_gecerli=0.
  - mesaj retains its last value after consumption.
- tasma:
  - Sticky; cleared by tasma_temizle.
  - A new overrun in the same cycle as tasma_temizle leaves tasma=1 (set wins).
- bit_sayisi reflects the registered counter and returns to 0 after completion, restart or timeout.

Test Plan:
- Basic frame: cerceve_basla, then 16 bit strobes of 1111000000001111 with mesaj_hazir=1 -> mesaj=16'hF00F and mesaj_gecerli=1 exactly one cycle after the 16th strobe. mesaj_gecerli drops the following cycle. tasma=0.
- Back-pressure/overrun: hold mesaj_hazir=0, send 0000111111110000 then 1010011010011110 -> mesaj stays 16'h0FF0, second word dropped, tasma=1. Pulse tasma_temizle -> tasma=0. Raise mesaj_hazir -> one transfer, then mesaj_gecerli=0.
- Same-cycle consume and load: hold 16'h0220, assert mesaj_hazir on the cycle the 16th bit of 1110000001101001 arrives -> mesaj=16'hE069 next cycle, mesaj_gecerli stays 1, tasma=0.
- Restart: 7 bits, then cerceve_basla together with the first bit of 0101010001000000, then 15 more bits -> mesaj=16'h5440. No timeout or overrun flag.
- Timeout (TIMEOUT=64): start, 5 bits, then 63 idle cycles -> zaman_asimi pulses for one cycle, bit_sayisi=0, state BOSTA. Later bits without cerceve_basla are ignored and mesaj_gecerli stays 0.
- Async reset mid-frame: assert rst_n=0 between clock edges after 9 bits -> all outputs 0 immediately. A full frame 0001000000010010 after release -> mesaj=16'h1012.
